data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter INDEX_BITS, default 6, meaning log2 of line count (64 lines, one 32-bit word per line).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ram_ce_i  input  1  CPU memory-stage request enable.
REQ-005 ram_re_i  input  1  CPU read request.
REQ-006 ram_we_i  input  1  CPU write request.
REQ-007 ram_addr_i  input  32  CPU byte address; bits [1:0] ignored.
REQ-008 ram_sel_i  input  4  CPU byte enables, bit n = byte lane n.
REQ-009 ram_data_i  input  32  CPU write data.
REQ-010 ram_data_o  output  32  read data to CPU, combinational.
REQ-011 stallreq_o  output  1  stall request to pipeline controller, combinational.
REQ-012 mem_req_o  output  1  backing-memory request, registered.
REQ-013 mem_we_o  output  1  backing-memory write (1) / read (0), registered.
REQ-014 mem_addr_o  output  32  backing-memory word address, [1:0]=0, registered.
REQ-015 mem_sel_o  output  4  backing-memory byte enables, registered.
REQ-016 mem_data_o  output  32  backing-memory write data, registered.
REQ-017 mem_data_i  input  32  backing-memory read data, valid with ack.
REQ-018 mem_ack_i  input  1  backing-memory completion, one-cycle pulse.

Function
REQ-019 Direct-mapped, write-through, no-write-allocate; index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; per line: valid bit, tag, 32-bit data.
REQ-020 Active request = ram_ce_i and (ram_re_i or ram_we_i); we has priority if both asserted; inactive request -> no stall, no state change, ram_data_o = 0.
REQ-021 FSM states IDLE, RD_MISS, WR_THRU, DONE.
REQ-022 IDLE, read hit: stallreq_o=0, ram_data_o = line data in the same cycle, stay IDLE.
REQ-023 IDLE, read miss: stallreq_o=1; next cycle RD_MISS with mem_req_o=1, mem_we_o=0, mem_sel_o=4'b1111, mem_addr_o = {addr[31:2],2'b00}.
REQ-024 IDLE, any write: stallreq_o=1; next cycle WR_THRU with mem_req_o=1, mem_we_o=1, mem_sel_o=ram_sel_i, mem_data_o=ram_data_i, mem_addr_o word-aligned.
REQ-025 Write hit: selected byte lanes of line updated at the IDLE->WR_THRU edge; write miss: cache contents unchanged.
REQ-026 RD_MISS/WR_THRU: stallreq_o=1; mem_* outputs held stable until mem_ack_i=1.
REQ-027 RD_MISS on ack: line written with mem_data_i, valid=1, tag set; mem_req_o=0 next cycle; go DONE.
REQ-028 WR_THRU on ack: mem_req_o=0 next cycle; go DONE.
REQ-029 DONE: stallreq_o=0; read returns line data (equal to filled word); write completes with no new memory access; next state IDLE.
REQ-030 Minimum miss/write penalty: 2 stall cycles (ack in first request cycle); each extra ack wait cycle adds one.
REQ-031 mem_ack_i ignored when mem_req_o=0.
REQ-032 CPU holds ram_* inputs stable while stallreq_o=1; block need not latch them except as stated in REQ-024.

Reset
REQ-033 On rst=1 at clock edge: state=IDLE, all valid bits=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_sel_o=0, mem_data_o=0.
REQ-034 While rst=1: stallreq_o=0, ram_data_o=0.
REQ-035 Reset during RD_MISS/WR_THRU aborts the transaction; a later stray ack is ignored (REQ-031); no line is filled.

Verification
REQ-036 Cold read 0x00000100, ack after 3 cycles with 0xDEADBEEF -> stall 5 cycles, ram_data_o=0xDEADBEEF in DONE, line valid.
REQ-037 Repeat read 0x00000100 -> stallreq_o=0, data 0xDEADBEEF same cycle, mem_req_o stays 0.
REQ-038 Write 0x00000100 sel=4'b0011 data 0x00001234, immediate ack -> mem_sel_o=0011, mem_data_o=0x00001234; subsequent read hit returns 0xDEAD1234.
REQ-039 Write miss 0x00000200 -> write-through issued, then read 0x00000200 misses (no allocate).
REQ-040 Read 0x00000100 then 0x00010100 (same index) -> second misses, refill replaces line; read 0x00000100 misses again.
REQ-041 Assert rst in RD_MISS, then ack -> state IDLE, mem_req_o=0, stallreq_o=0, line invalid.

Source files
------------

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-through, no-write-allocate data cache between the
// CPU memory stage and a simple request/ack backing memory. Each line holds
// one 32-bit word together with a valid bit and a tag.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   ram_ce_i        : CPU request enable
//   ram_re_i        : CPU read request
//   ram_we_i        : CPU write request (wins over read)
//   ram_addr_i      : CPU byte address, bits [1:0] unused
//   ram_sel_i       : CPU byte enables
//   ram_data_i      : CPU write data
//   ram_data_o      : read data to CPU (combinational)
//   stallreq_o      : pipeline stall request (combinational)
//   mem_req_o       : backing-memory request (registered)
//   mem_we_o        : backing-memory write / read select (registered)
//   mem_addr_o      : backing-memory word address (registered)
//   mem_sel_o       : backing-memory byte enables (registered)
//   mem_data_o      : backing-memory write data (registered)
//   mem_data_i      : backing-memory read data, valid with ack
//   mem_ack_i       : backing-memory completion pulse
// ---------------------------------------------------------------------------
module data_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_re_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_sel_q;
  logic [31:0] mem_data_q;

  logic [INDEX_BITS-1:0] reqIndex;
  logic [TAG_BITS-1:0]   reqTag;
  logic                  reqActive;
  logic                  reqWrite;
  logic                  lineHit;
  logic [31:0]           lineData;
  logic [31:0]           lineMerged_d;
  logic                  unused_addr;

  // Address decode and hit detection. Write wins when both re and we are
  // raised, so a request is a write whenever we is set.
  assign reqIndex    = ram_addr_i[INDEX_BITS+1:2];
  assign reqTag      = ram_addr_i[31:INDEX_BITS+2];
  assign reqActive   = ram_ce_i & (ram_re_i | ram_we_i);
  assign reqWrite    = ram_we_i;
  assign lineData    = data_q[reqIndex];
  assign lineHit     = valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);
  assign unused_addr = ^ram_addr_i[1:0];

  // Byte-lane merge of the CPU write data into the resident line, used only
  // when a write hits so the cached copy stays coherent with memory.
  always_comb begin
    lineMerged_d = lineData;
    for (int n = 0; n < 4; n++) begin
      if (ram_sel_i[n]) begin
        lineMerged_d[8*n +: 8] = ram_data_i[8*n +: 8];
      end
    end
  end

  // CPU-facing outputs. Only a read hit in IDLE is serviced without a
  // stall; in DONE the line has just been filled (read) or the write has
  // been acknowledged, so the pipeline is released.
  always_comb begin
    stallreq_o = 1'b0;
    ram_data_o = '0;
    if (!rst && reqActive) begin
      case (state_q)
        IDLE: begin
          if (reqWrite) begin
            stallreq_o = 1'b1;
          end else if (lineHit) begin
            ram_data_o = lineData;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        RD_MISS, WR_THRU: begin
          stallreq_o = 1'b1;
        end
        DONE: begin
          if (!reqWrite) begin
            ram_data_o = lineData;
          end
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

  // Controller, cache arrays and registered memory interface. The CPU holds
  // its request stable while stalled, so the refill uses the live address.
  // An ack only counts while a request is outstanding, which makes a stray
  // ack after a reset-aborted transaction harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_sel_q  <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqActive) begin
            if (reqWrite) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {ram_addr_i[31:2], 2'b00};
              mem_sel_q  <= ram_sel_i;
              mem_data_q <= ram_data_i;
              state_q    <= WR_THRU;
              if (lineHit) begin
                data_q[reqIndex] <= lineMerged_d;
              end
            end else if (!lineHit) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {ram_addr_i[31:2], 2'b00};
              mem_sel_q  <= 4'b1111;
              state_q    <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack_i && mem_req_q) begin
            data_q[reqIndex]  <= mem_data_i;
            tag_q[reqIndex]   <= reqTag;
            valid_q[reqIndex] <= 1'b1;
            mem_req_q         <= 1'b0;
            state_q           <= DONE;
          end
        end
        WR_THRU: begin
          if (mem_ack_i && mem_req_q) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_sel_o  = mem_sel_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
// Directed testbench for data_cache: cold misses with varying memory
// latency, read hits, byte-lane write hits, write misses without allocation,
// index aliasing / replacement, and reset aborting an outstanding refill.
// Expected values are hand-computed from the address map (all of 0x100,
// 0x200 and 0x00010100 map to index 0 with tags 0x1, 0x2 and 0x101).
// ---------------------------------------------------------------------------
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_re_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  int vectorCount = 0;
  int missCount   = 0;

  always #5 clk = ~clk;

  data_cache #(.INDEX_BITS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .ram_ce_i   (ram_ce_i),
    .ram_re_i   (ram_re_i),
    .ram_we_i   (ram_we_i),
    .ram_addr_i (ram_addr_i),
    .ram_sel_i  (ram_sel_i),
    .ram_data_i (ram_data_i),
    .ram_data_o (ram_data_o),
    .stallreq_o (stallreq_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_sel_o  (mem_sel_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives the CPU-side request inputs.
  task automatic applyStimulus(input logic ce, input logic re, input logic we,
                               input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] data);
    ram_ce_i   = ce;
    ram_re_i   = re;
    ram_we_i   = we;
    ram_addr_i = addr;
    ram_sel_i  = sel;
    ram_data_i = data;
  endtask

  // Advances one clock; the ack is a one-cycle pulse, so it is dropped just
  // after the edge. Outputs are then sampled 2 time units past the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
  endtask

  // Runs a stalled transaction: counts stall cycles, checks the memory-side
  // request every cycle it is raised, and acks after waitCycles idle request
  // cycles. Bounded so a stuck stall shows up as a wrong stall count.
  task automatic serviceTransaction(input string tag, input int waitCycles,
                                    input logic [31:0] ackData, input logic expWe,
                                    input logic [31:0] expAddr, input logic [3:0] expSel,
                                    input logic checkData, input logic [31:0] expData,
                                    input int expStalls);
    int stalls;
    int reqCycles;
    stalls    = 0;
    reqCycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (stallreq_o !== 1'b1) break;
      stalls++;
      if (mem_req_o === 1'b1) begin
        checkOutput({tag, "_mem_we"},   32'(mem_we_o),  32'(expWe));
        checkOutput({tag, "_mem_addr"}, mem_addr_o,     expAddr);
        checkOutput({tag, "_mem_sel"},  32'(mem_sel_o), 32'(expSel));
        if (checkData) begin
          checkOutput({tag, "_mem_data"}, mem_data_o, expData);
        end
        if (reqCycles == waitCycles) begin
          mem_ack_i  = 1'b1;
          mem_data_i = ackData;
        end
        reqCycles++;
      end
      nextCycle();
    end
    checkOutput({tag, "_stalls"}, 32'(stalls), 32'(expStalls));
  endtask

  // One CPU read: a hit must return data with no stall and no memory
  // request; a miss must stall 2 + waitCycles and return the fill in DONE.
  task automatic doRead(input string tag, input logic [31:0] addr, input logic expectHit,
                        input int waitCycles, input logic [31:0] ackData,
                        input logic [31:0] expData);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 4'hF, 32'h0);
    #1;
    checkOutput({tag, "_stall"}, 32'(stallreq_o), expectHit ? 32'd0 : 32'd1);
    if (expectHit) begin
      checkOutput({tag, "_hit_data"}, ram_data_o, expData);
      checkOutput({tag, "_hit_req"}, 32'(mem_req_o), 32'd0);
    end else begin
      serviceTransaction(tag, waitCycles, ackData, 1'b0, {addr[31:2], 2'b00}, 4'hF,
                         1'b0, 32'h0, 2 + waitCycles);
      checkOutput({tag, "_done_data"}, ram_data_o, expData);
      checkOutput({tag, "_done_req"}, 32'(mem_req_o), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();
  endtask

  // One CPU write: always written through, stalling 2 + waitCycles.
  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, input int waitCycles);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, sel, data);
    #1;
    checkOutput({tag, "_stall"}, 32'(stallreq_o), 32'd1);
    serviceTransaction(tag, waitCycles, 32'h0, 1'b1, {addr[31:2], 2'b00}, sel,
                       1'b1, data, 2 + waitCycles);
    checkOutput({tag, "_done_req"}, 32'(mem_req_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();
  endtask

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();
    nextCycle();

    // Reset values of all registered outputs.
    checkOutput("rst_mem_req",  32'(mem_req_o),  32'd0);
    checkOutput("rst_mem_we",   32'(mem_we_o),   32'd0);
    checkOutput("rst_mem_addr", mem_addr_o,      32'd0);
    checkOutput("rst_mem_sel",  32'(mem_sel_o),  32'd0);
    checkOutput("rst_mem_data", mem_data_o,      32'd0);

    // A request presented during reset must neither stall nor return data.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    #1;
    checkOutput("rst_stall", 32'(stallreq_o), 32'd0);
    checkOutput("rst_data",  ram_data_o,      32'd0);
    nextCycle();
    checkOutput("rst_hold_req", 32'(mem_req_o), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    rst = 1'b0;
    nextCycle();

    // ce low: the request is inactive.
    checkOutput("inactive_stall", 32'(stallreq_o), 32'd0);
    checkOutput("inactive_data",  ram_data_o,      32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Cold read with three ack wait cycles: 5 stall cycles.
    doRead("coldRead", 32'h0000_0100, 1'b0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Repeat read hits with no memory traffic.
    doRead("hitRead", 32'h0000_0100, 1'b1, 0, 32'h0, 32'hDEAD_BEEF);
    checkOutput("hitRead_after_req", 32'(mem_req_o), 32'd0);

    // Byte-lane write hit, immediate ack; lanes 0/1 merged into the line.
    doWrite("wrHit", 32'h0000_0100, 4'b0011, 32'h0000_1234, 0);
    doRead("afterWr", 32'h0000_0100, 1'b1, 0, 32'h0, 32'hDEAD_1234);

    // Write miss on the same index: written through, line left untouched.
    doWrite("wrMiss", 32'h0000_0200, 4'hF, 32'hCAFE_F00D, 1);
    doRead("line0Kept", 32'h0000_0100, 1'b1, 0, 32'h0, 32'hDEAD_1234);
    doRead("noAlloc", 32'h0000_0200, 1'b0, 0, 32'h1111_2222, 32'h1111_2222);

    // Aliasing addresses on index 0 replace each other.
    doRead("evict1",    32'h0000_0100, 1'b0, 2, 32'hAAAA_0001, 32'hAAAA_0001);
    doRead("alias",     32'h0001_0100, 1'b0, 0, 32'hBBBB_0002, 32'hBBBB_0002);
    doRead("evict2",    32'h0000_0100, 1'b0, 1, 32'hCCCC_0003, 32'hCCCC_0003);
    doRead("evict2Hit", 32'h0000_0100, 1'b1, 0, 32'h0, 32'hCCCC_0003);

    // Reset during a refill aborts it; a late ack is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0104, 4'hF, 32'h0);
    #1;
    checkOutput("abort_idle_stall", 32'(stallreq_o), 32'd1);
    nextCycle();
    checkOutput("abort_rdmiss_req", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    nextCycle();
    checkOutput("abort_req",   32'(mem_req_o),  32'd0);
    checkOutput("abort_stall", 32'(stallreq_o), 32'd0);
    checkOutput("abort_data",  ram_data_o,      32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h5555_5555;
    nextCycle();
    checkOutput("strayAck_req",   32'(mem_req_o),  32'd0);
    checkOutput("strayAck_stall", 32'(stallreq_o), 32'd0);

    // The aborted line was never filled, and reset cleared index 0 too.
    doRead("afterAbort", 32'h0000_0104, 1'b0, 0, 32'h7777_7777, 32'h7777_7777);
    doRead("rstClears",  32'h0000_0100, 1'b0, 0, 32'h9999_0000, 32'h9999_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
